// File: rtl/mips_pkg.sv
// mips_pkg: fetch FSM states, opcode field bounds and opcode constants shared with the decoder.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} fetch_state_t;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int INSTR_BYTES = 4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding imem fetch with redirect squash, valid/ready decode register.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [5:0]        id_op,
  output logic [ADDR_W-1:0] id_pc4
);
  fetch_state_t state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] target;
  logic drop;
  assign target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc4 = pc + ADDR_W'(INSTR_BYTES);
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign id_valid = state == FULL;
  assign id_op = id_instr[OP_MSB:OP_LSB];
  // drop marks a granted fetch whose response must be discarded after a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      id_instr <= '0;
      id_pc4 <= '0;
    end else begin
      if (redirect) pc <= target;
      case (state)
        IDLE: state <= REQ;
        REQ: if (imem_gnt) begin
          state <= WAIT;
          drop <= redirect;
        end
        WAIT: if (imem_rvalid) begin
          drop <= 1'b0;
          if (drop || redirect) state <= REQ;
          else begin
            state <= FULL;
            id_instr <= imem_rdata;
            id_pc4 <= pc4;
            pc <= pc4;
          end
        end else if (redirect) drop <= 1'b1;
        FULL: if (redirect || id_ready) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch/redirect/reset vectors with a queue scoreboard checked by a decode-side monitor.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt = 1'b0;
  logic imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic id_valid;
  logic id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [5:0] id_op;
  logic [31:0] id_pc4;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic outst = 1'b0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_op(id_op), .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input logic [31:0] rpc);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'(rpc));
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(id_instr), 64'd0);
    check("rst_op", 64'(id_op), 64'd0);
    check("rst_pc4", 64'(id_pc4), 64'd0);
  endtask

  // issue one fetch: wait for req, grant after gd cycles, return data rd cycles after grant
  task automatic fetch(input logic [31:0] instr, input int gd, input int rd);
    int n = 0;
    logic [31:0] a;
    while (!imem_req && n < 20) begin
      tick;
      n++;
    end
    check("req_seen", 64'(imem_req), 64'd1);
    a = imem_addr;
    repeat (gd) tick;
    check("req_held", 64'(imem_req), 64'd1);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    sb.push_back({instr, a + 32'd4});
    repeat (rd - 1) tick;
    check("valid_early", 64'(id_valid), 64'd0);
    imem_rdata = instr;
    imem_rvalid = 1'b1;
    tick;
    imem_rvalid = 1'b0;
    check("valid_latency", 64'(id_valid), 64'd1);
  endtask

  task automatic consume;
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    check("valid_fall", 64'(id_valid), 64'd0);
    check("req_after_ready", 64'(imem_req), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect) begin
      if (sb.size() == 0) check("unexpected_instr", 64'(id_instr), 64'hx);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("sb_instr", 64'(id_instr), 64'(e[63:32]));
        check("sb_pc4", 64'(id_pc4), 64'(e[31:0]));
      end
    end
  end

  always @(posedge clk) begin
    if (rst) outst <= 1'b0;
    else begin
      if (imem_rvalid && !outst) begin
        errors++;
        $display("FAIL rvalid_protocol: rvalid with no outstanding request");
      end
      if (imem_req && imem_gnt) outst <= 1'b1;
      else if (imem_rvalid) outst <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    repeat (3) tick;
    check_reset_vals(32'h0);
    rst = 1'b0;
    tick;
    check("first_req", 64'(imem_req), 64'd1);
    fetch(32'h8C22_0004, 0, 1);
    check("op_lw", 64'(id_op), 64'h23);
    consume;
    check("addr_4", 64'(imem_addr), 64'h4);
    fetch(32'hAC43_0008, 2, 3);
    check("op_sw", 64'(id_op), 64'h2B);
    held = id_instr;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold_valid", 64'(id_valid), 64'd1);
      check("hold_instr", 64'(id_instr), 64'(held));
      check("hold_noreq", 64'(imem_req), 64'd0);
    end
    consume;
    check("addr_8", 64'(imem_addr), 64'h8);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick;
    redirect = 1'b0;
    imem_rdata = 32'h1000_FFFF;
    imem_rvalid = 1'b1;
    tick;
    imem_rvalid = 1'b0;
    check("drop_valid", 64'(id_valid), 64'd0);
    check("drop_req", 64'(imem_req), 64'd1);
    check("drop_addr", 64'(imem_addr), 64'h100);
    fetch(32'h1000_0005, 0, 1);
    check("op_beq", 64'(id_op), 64'h04);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    id_ready = 1'b1;
    tick;
    redirect = 1'b0;
    id_ready = 1'b0;
    void'(sb.pop_back());
    check("squash_valid", 64'(id_valid), 64'd0);
    check("squash_addr", 64'(imem_addr), 64'h200);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick;
    redirect = 1'b0;
    check("req_redir_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    fetch(32'h0000_0020, 0, 2);
    check("op_rtype", 64'(id_op), 64'h00);
    consume;
    check("wrap_addr", 64'(imem_addr), 64'h0);
    fetch(32'h0043_2020, 1, 1);
    consume;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick;
    check_reset_vals(32'h0);
    rst = 1'b0;
    tick;
    check("rereq", 64'(imem_req), 64'd1);
    check("rereq_addr", 64'(imem_addr), 64'h0);
    imem_gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0041;
    tick;
    imem_gnt = 1'b0;
    redirect = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    imem_rvalid = 1'b1;
    tick;
    imem_rvalid = 1'b0;
    check("gnt_redir_valid", 64'(id_valid), 64'd0);
    check("gnt_redir_addr", 64'(imem_addr), 64'h40);
    fetch(32'h8C22_0004, 0, 1);
    consume;
    check("final_addr", 64'(imem_addr), 64'h44);
    tick;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS datapath. Holds the PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and presents the fetched word to the main control decoder (opcode field) and the rest of decode through a valid/ready output register. Accepts a branch redirect from downstream (beq resolution) and discards any in-flight fetch made stale by it.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `DATA_W`, default 32: instruction width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `imem_req`, out, 1: fetch request valid.
- `imem_addr`, out, `ADDR_W`: fetch address; always equals PC.
- `imem_gnt`, in, 1: memory accepts request this cycle. Only meaningful with `imem_req`.
- `imem_rvalid`, in, 1: read data valid. Exactly one per granted request, ≥1 cycle after gnt.
- `imem_rdata`, in, `DATA_W`: instruction word.
- `redirect`, in, 1: branch taken; load `redirect_pc`.
- `redirect_pc`, in, `ADDR_W`: branch target.
- `id_valid`, out, 1: `id_*` outputs hold a valid instruction.
- `id_ready`, in, 1: decode consumes the instruction this cycle.
- `id_instr`, out, `DATA_W`: fetched instruction.
- `id_op`, out, 6: `id_instr[31:26]`, feeds the control decoder's `Op`.
- `id_pc4`, out, `ADDR_W`: address of instruction + 4.

## Operation
- FSM states:
  - IDLE: reset state.
  - REQ: `imem_req`=1.
  - WAIT: request granted, awaiting `imem_rvalid`.
  - FULL: `id_valid`=1.
- Transitions, evaluated with `redirect` at highest priority:
  - IDLE → REQ unconditionally.
  - REQ: with `gnt` → WAIT; otherwise stay.
  - WAIT: with `rvalid` → FULL. Load `id_instr`=`rdata` and `id_pc4`=PC+4. PC←PC+4.
  - FULL: with `id_ready` → REQ; otherwise hold all `id_*` stable.
- Redirect: PC←{`redirect_pc`[31:2], 2'b00}. Low two bits are forced to zero.
  - In REQ without gnt: stay in REQ. Address changes next cycle; the memory tolerates a withdrawn or changed ungranted request.
  - In REQ with gnt same cycle: go to WAIT with `drop`=1.
  - In WAIT: set `drop`=1 and stay. When `rvalid` arrives with `drop`=1, discard the data, clear `drop`, and go to REQ. If `redirect` and `rvalid` occur in the same WAIT cycle, discard the data and go to REQ.
  - In FULL: clear `id_valid` and go to REQ. A simultaneous `id_ready` is ignored, because the instruction is squashed.
  - In IDLE: PC←target; go to REQ.
- PC+4 wraps modulo 2^`ADDR_W`. 32'hFFFF_FFFC + 4 = 0.
- At most one outstanding request. `rvalid` outside WAIT is a protocol error: ignore it. The bench asserts that it never occurs.
- Reset mid-operation clears `drop` and state. Instruction memory shares `rst`, so no pre-reset response arrives after reset.

## Timing
- All outputs are registered or decoded from state/PC registers. There is no combinational path from any input to any output.
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `id_valid`=0
  - `id_instr`=0
  - `id_op`=0
  - `id_pc4`=0
- First `imem_req` is in the cycle after `rst` falls.
- Latency with gnt on first REQ cycle and rvalid N cycles after gnt: `id_valid` rises N cycles after the gnt edge.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, FULL with immediate ready, N=1).
- `id_valid` falls the cycle after the consuming `id_ready`. The next `imem_req` is in that same cycle.
- Redirect takes effect on the next edge: the following REQ carries the target address.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, WAIT, FULL}
  - `OP_MSB`=31, `OP_LSB`=26
  - `INSTR_BYTES`=4
  - opcode constants `OP_RTYPE`=6'h00, `OP_LW`=6'h23, `OP_SW`=6'h2B, `OP_BEQ`=6'h04, shared with the control decoder.
- No sub-module. PC register, FSM, and output register live in one module.

## Test plan
- Reset release, `RESET_PC`=0, gnt immediate, rvalid 1 cycle later with 32'h8C22_0004 → `id_valid` cycle 3. `id_op`=6'h23, `id_pc4`=4, next `imem_addr`=4 after `id_ready`.
- Hold `id_ready`=0 for 5 cycles in FULL → `id_*` stable, `imem_req`=0 throughout. Ready → next request to PC+4.
- Redirect to 32'h0000_0103 in WAIT, then rvalid with 32'h1000_FFFF → data discarded, `id_valid` stays 0, next `imem_addr`=32'h0000_0100.
- Redirect and `id_ready` same cycle in FULL → instruction squashed, next `imem_addr`=target, `id_valid`=0.
- PC=32'hFFFF_FFFC fetch completes → `id_pc4`=0, next `imem_addr`=0.
- Assert `rst` while in WAIT → next cycle all outputs at reset values, `imem_addr`=`RESET_PC`, request re-issued after release.
